// File: rtl/l2_model_pkg.sv
// rtl/l2_model_pkg.sv - shared constants, sizing helpers and FSM state type for the L2 burst model
package l2_model_pkg;

  localparam int DEF_B = 9;
  localparam int DEF_W = 7;

  localparam int L2_BUS_WIDTH   = 1 << DEF_W;
  localparam int L2_BURST       = 1 << (DEF_B - DEF_W);
  localparam int WORDS_PER_BEAT = 1 << (DEF_W - 5);
  localparam int BEAT_IDX_W     = DEF_B - DEF_W;

  function automatic int bus_width(input int w);
    return 1 << w;
  endfunction

  function automatic int beat_idx_w(input int b, input int w);
    return b - w;
  endfunction

  function automatic int word_idx_w(input int w);
    return w - 5;
  endfunction

  // Block address field of a request entry: word address minus the word-in-block bits.
  function automatic int blk_addr_w(input int addr_width, input int b);
    return (addr_width - 2) - (b - 5);
  endfunction

  function automatic int timer_w(input int l2_delay, input int depth);
    return $clog2(l2_delay) + $clog2(depth) + 2;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } l2_state_t;

endpackage

// File: rtl/l2_req_fifo.sv
// rtl/l2_req_fifo.sv - synchronous request queue exposing the head and the entry behind it
module l2_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           next_head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW-1:0]    rd_idx_nx;

  assign rd_idx_nx = rd_ptr[PW-1:0] + PW'(1);
  assign head      = mem[rd_ptr[PW-1:0]];
  assign next_head = mem[rd_idx_nx];
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/l2_burst_responder.sv
// rtl/l2_burst_responder.sv - L2 refill model: queued misses returned as timed, address-patterned bursts
module l2_burst_responder
  import l2_model_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int B          = 9,
  parameter int W          = 7,
  parameter int L2_DELAY   = 7,
  parameter int DEPTH      = 4,
  parameter int CRIT_FIRST = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-3:0]   ADDR_IN,
  input  logic                    ADDR_VALID,
  output logic                    ADDR_READY,
  output logic [(1<<W)-1:0]       DATA_OUT,
  output logic                    DATA_VALID,
  input  logic                    DATA_READY,
  output logic                    DATA_LAST,
  output logic                    BUSY
);

  localparam int BUS = bus_width(W);
  localparam int BIW = beat_idx_w(B, W);
  localparam int WIW = word_idx_w(W);
  localparam int WPB = 1 << WIW;
  localparam int BAW = blk_addr_w(ADDR_WIDTH, B);
  localparam int TW  = timer_w(L2_DELAY, DEPTH);
  localparam int EW  = BAW + BIW + TW;
  localparam int CW  = $clog2(DEPTH) + 1;

  l2_state_t       state, state_next;
  logic [BIW-1:0]  beat_cnt, beat_cnt_next;
  logic [TW-1:0]   timer;

  logic [EW-1:0]   push_entry, head, next_head;
  logic            full, empty, push, pop;
  logic [CW-1:0]   count;

  logic [BAW-1:0]  head_blk;
  logic [BIW-1:0]  head_start, beat_idx, req_start;
  logic [TW-1:0]   head_due, next_due, head_diff, next_diff;
  logic            head_due_nx, next_due_nx;
  logic [ADDR_WIDTH-3:0] unused_addr_bits;
  logic [EW-TW-1:0]      unused_next_fields;

  assign unused_addr_bits   = ADDR_IN;
  assign unused_next_fields = next_head[EW-1:TW];

  // Critical-word-first starts at the beat holding the requested word.
  assign req_start  = (CRIT_FIRST != 0) ? ADDR_IN[B-6 -: BIW] : '0;
  assign push       = ADDR_VALID && !full;
  assign push_entry = {ADDR_IN[ADDR_WIDTH-3 -: BAW], req_start, timer + TW'(L2_DELAY + 1)};

  l2_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign {head_blk, head_start, head_due} = head;
  assign next_due = next_head[TW-1:0];

  // Wrap-safe: an entry is due at the coming edge once (timer+1 - due) is non-negative.
  assign head_diff   = timer + TW'(1) - head_due;
  assign next_diff   = timer + TW'(1) - next_due;
  assign head_due_nx = !head_diff[TW-1];
  assign next_due_nx = !next_diff[TW-1];

  assign DATA_VALID = (state == S_BURST);
  assign DATA_LAST  = DATA_VALID && (&beat_cnt);
  assign pop        = DATA_LAST && DATA_READY;
  assign ADDR_READY = !full;
  assign BUSY       = !empty;
  assign beat_idx   = head_start + beat_cnt;

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    case (state)
      S_IDLE: begin
        if (push) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (head_due_nx) begin
          state_next    = S_BURST;
          beat_cnt_next = '0;
        end
      end
      S_BURST: begin
        if (DATA_READY) begin
          beat_cnt_next = beat_cnt + BIW'(1);
          if (DATA_LAST) begin
            beat_cnt_next = '0;
            if (count > CW'(1)) begin
              state_next = next_due_nx ? S_BURST : S_WAIT;
            end else if (push) begin
              state_next = S_WAIT;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      timer    <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      timer    <= timer + TW'(1);
    end
  end

  // Word l of the current beat carries its own byte address.
  always_comb begin
    logic [ADDR_WIDTH-1:0] byte_addr;
    DATA_OUT  = '0;
    byte_addr = '0;
    if (state == S_BURST) begin
      for (int l = 0; l < WPB; l++) begin
        byte_addr = {head_blk, beat_idx, WIW'(l), 2'b00};
        DATA_OUT[l*32 +: 32] = 32'(byte_addr);
      end
    end
  end

  logic [BUS-1:0] unused_bus_check;
  assign unused_bus_check = DATA_OUT;

endmodule

// File: tb/tb_l2_burst_responder.sv
// tb/tb_l2_burst_responder.sv - scoreboard bench for l2_burst_responder (normal and critical-first)
module tb_l2_burst_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [29:0]  addr_in    = '0;
  logic         addr_valid = 1'b0;
  logic         addr_ready;
  logic [127:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b1;
  logic         data_last;
  logic         busy;

  logic [29:0]  c_addr_in    = '0;
  logic         c_addr_valid = 1'b0;
  logic         c_addr_ready;
  logic [127:0] c_data_out;
  logic         c_data_valid;
  logic         c_data_ready = 1'b1;
  logic         c_data_last;
  logic         c_busy;

  l2_burst_responder dut (
    .CLK(CLK), .RST(RST), .ADDR_IN(addr_in), .ADDR_VALID(addr_valid), .ADDR_READY(addr_ready),
    .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_READY(data_ready),
    .DATA_LAST(data_last), .BUSY(busy)
  );

  l2_burst_responder #(.CRIT_FIRST(1)) dut_c (
    .CLK(CLK), .RST(RST), .ADDR_IN(c_addr_in), .ADDR_VALID(c_addr_valid), .ADDR_READY(c_addr_ready),
    .DATA_OUT(c_data_out), .DATA_VALID(c_data_valid), .DATA_READY(c_data_ready),
    .DATA_LAST(c_data_last), .BUSY(c_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [128:0] sb [$];
  logic [128:0] mon_exp;
  int run_len = 0;
  int max_run = 0;

  function automatic logic [127:0] beat_data(input logic [31:0] base, input int k);
    logic [127:0] d;
    for (int l = 0; l < 4; l++) d[l*32 +: 32] = base + 32'(k * 16) + 32'(l * 4);
    return d;
  endfunction

  function automatic logic [31:0] block_base(input logic [29:0] a);
    return {a, 2'b00} & 32'hFFFF_FFC0;
  endfunction

  task automatic push_expected(input logic [29:0] a);
    for (int k = 0; k < 4; k++) sb.push_back({(k == 3), beat_data(block_base(a), k)});
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      run_len = 0;
    end else begin
      if (data_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (data_valid && data_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected got last=%b data=%h, required no beat", data_last, data_out);
        end else begin
          mon_exp = sb.pop_front();
          if ({data_last, data_out} !== mon_exp) begin
            miscompares++;
            $display("FAIL beat_data got last=%b data=%h, required last=%b data=%h",
                     data_last, data_out, mon_exp[128], mon_exp[127:0]);
          end
        end
      end
    end
  end

  task automatic send_req(input logic [29:0] a);
    int g = 0;
    addr_in = a;
    addr_valid = 1'b1;
    while (!addr_ready && g < 100) begin
      @(posedge CLK); #1;
      g++;
    end
    if (!addr_ready) begin
      miscompares++;
      $display("FAIL send_timeout got addr_ready=0, required 1 within 100 cycles");
    end
    @(posedge CLK); #1;
    addr_valid = 1'b0;
    push_expected(a);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 300) begin
      @(posedge CLK); #1;
      g++;
    end
    vectors++;
    if (busy || sb.size() != 0) begin
      miscompares++;
      $display("FAIL idle_timeout got busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    @(negedge CLK);
    while (!data_valid && g < 100) begin
      @(negedge CLK);
      g++;
    end
    vectors++;
    if (!data_valid) begin
      miscompares++;
      $display("FAIL valid_timeout got data_valid=0, required 1 within 100 cycles");
    end
  endtask

  task automatic check_latency(input string name);
    int lat = 0;
    @(negedge CLK);
    while (!data_valid && lat < 50) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    vectors++;
    if (lat != 7) begin
      miscompares++;
      $display("FAIL %s got %0d cycles, required 7", name, lat);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({addr_ready, data_valid, data_last, busy} !== 4'b1000 || data_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b vld=%b last=%b busy=%b data=%h, required 1 0 0 0 0",
               addr_ready, data_valid, data_last, busy, data_out);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_single();
    data_ready = 1'b1;
    send_req(30'h10);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy got %b, required 1", busy);
    end
    check_latency("single_latency");
    wait_idle();
  endtask

  task automatic test_crit_first();
    int g = 0;
    int k;
    c_addr_in = 30'h1A;
    c_addr_valid = 1'b1;
    @(posedge CLK); #1;
    c_addr_valid = 1'b0;
    @(negedge CLK);
    while (!c_data_valid && g < 50) begin
      @(negedge CLK);
      g++;
    end
    for (int i = 0; i < 4; i++) begin
      k = (2 + i) % 4;
      vectors++;
      if ({c_data_valid, c_data_last, c_data_out} !== {1'b1, (i == 3), beat_data(32'h40, k)}) begin
        miscompares++;
        $display("FAIL crit_beat%0d got vld=%b last=%b data=%h, required vld=1 last=%b data=%h",
                 i, c_data_valid, c_data_last, c_data_out, (i == 3), beat_data(32'h40, k));
      end
      @(negedge CLK);
    end
    vectors++;
    if (c_data_valid !== 1'b0 || c_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL crit_end got vld=%b busy=%b, required 0 0", c_data_valid, c_busy);
    end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    logic lastflag = 1'b0;
    data_ready = 1'b1;
    max_run = 0;
    for (int i = 0; i < 4; i++) send_req(30'h100 + 30'(i * 16));
    vectors++;
    if (addr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready got %b, required 0", addr_ready);
    end
    addr_in = 30'h140;
    addr_valid = 1'b1;
    while (g < 100) begin
      @(negedge CLK);
      lastflag = data_valid && data_ready && data_last;
      @(posedge CLK); #1;
      g++;
      if (addr_ready) break;
    end
    vectors++;
    if (!addr_ready || !lastflag) begin
      miscompares++;
      $display("FAIL ready_rise got ready=%b after_last=%b, required 1 1", addr_ready, lastflag);
    end
    @(posedge CLK); #1;
    addr_valid = 1'b0;
    push_expected(30'h140);
    wait_idle();
    vectors++;
    if (max_run != 20) begin
      miscompares++;
      $display("FAIL b2b_run got %0d consecutive valid, required 20", max_run);
    end
  endtask

  task automatic test_stall_toggle();
    logic [7:0] pat = 8'b1101_0010;
    logic [127:0] snap;
    logic snap_last;
    logic prev_stall;
    data_ready = 1'b0;
    send_req(30'h200);
    wait_valid();
    snap = data_out;
    snap_last = data_last;
    prev_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      data_ready = pat[i];
      @(negedge CLK);
      if (prev_stall) begin
        vectors++;
        if (data_out !== snap || data_last !== snap_last) begin
          miscompares++;
          $display("FAIL stall_hold got last=%b data=%h, required last=%b data=%h",
                   data_last, data_out, snap_last, snap);
        end
      end
      snap = data_out;
      snap_last = data_last;
      prev_stall = data_valid && !data_ready;
    end
    @(posedge CLK); #1;
    data_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    send_req(30'h400);
    send_req(30'h410);
    send_req(30'h420);
    wait_valid();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sb.delete();
    vectors++;
    if ({data_valid, busy, addr_ready, data_last} !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_reset got vld=%b busy=%b rdy=%b last=%b, required 0 0 1 0",
               data_valid, busy, addr_ready, data_last);
    end
    send_req(30'h500);
    check_latency("reset_latency");
    wait_idle();
  endtask

  task automatic test_long_stall();
    data_ready = 1'b0;
    send_req(30'h300);
    send_req(30'h310);
    wait_valid();
    repeat (20) @(posedge CLK);
    #1;
    data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      vectors++;
      if (data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_gap beat %0d got data_valid=%b, required 1", i, data_valid);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_crit_first();
    test_back_to_back();
    test_stall_toggle();
    test_reset_mid();
    test_long_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
